pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer side of the hazard-detection/forwarding interface. Turns the load-use stall request
//  from the hazard unit, plus branch/jump redirects and memory-busy, into per-stage write-enable
//  and flush controls for the PipelineCPU IF/ID/EX/MEM/WB registers.
//  Times out a stuck memory into a sticky halt state and keeps saturating stall/flush
//  performance counters.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive Mem_Busy cycles tolerated; more -> TRAP (>=1)
//  CNT_W        16   width of Stall_Count / Flush_Count
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  LW_Stall      in   1      load-use hazard from hazard unit (ID stage)
//  Jump          in   1      jump decoded in ID; PC redirect this cycle
//  Branch_Taken  in   1      branch resolved taken in EX; PC redirect this cycle
//  Mem_Busy      in   1      data memory not ready; MEM stage must hold
//  PC_Write      out  1      PC register load enable
//  IF_ID_Write   out  1      IF/ID register load enable
//  IF_ID_Flush   out  1      IF/ID -> NOP
//  ID_EX_Write   out  1      ID/EX register load enable
//  ID_EX_Flush   out  1      ID/EX -> bubble (control bits cleared)
//  EX_MEM_Write  out  1      EX/MEM register load enable
//  MEM_WB_Flush  out  1      MEM/WB -> bubble
//  Halted        out  1      sticky: memory timeout, pipeline frozen
//  Stall_Count   out  CNT_W  cycles with PC_Write=0 (saturating)
//  Flush_Count   out  CNT_W  cycles in which a branch/jump flush was applied (saturating)
// BEHAVIOUR
//  State: RUN, MEM_WAIT, TRAP; wait_cnt [$clog2(MEM_TIMEOUT+1)-1:0].
//  Reset (async): state=RUN, wait_cnt=0, Halted=0, both counters 0.
//  While reset high, outputs are forced: all *_Write=0, all *_Flush=1.
//  Defaults (no request): all *_Write=1, all *_Flush=0. Outputs are combinational from the
//  current inputs and state, so they take effect on the same clock edge.
//  Per-cycle priority in RUN/MEM_WAIT (highest first):
//   1 Mem_Busy: PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, MEM_WB_Flush=1,
//     no other flush. Branch/Jump/LW_Stall are ignored; they stay asserted because the
//     pipeline is frozen, and act in the first cycle with Mem_Busy=0.
//   2 Branch_Taken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. Overrides LW_Stall and Jump.
//   3 LW_Stall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Overrides Jump, so a jr waiting
//     on a load stalls first.
//   4 Jump: IF_ID_Flush=1, PC_Write=1.
//  Transitions:
//   RUN, Mem_Busy=1 -> MEM_WAIT, wait_cnt<=1.
//   MEM_WAIT, Mem_Busy=1 and wait_cnt==MEM_TIMEOUT -> TRAP; else wait_cnt<=wait_cnt+1.
//   MEM_WAIT, Mem_Busy=0 -> RUN, wait_cnt<=0. Priorities 2-4 apply in that same cycle.
//   TRAP -> TRAP until reset.
//  Net effect: Mem_Busy high for MEM_TIMEOUT consecutive cycles -> no trap;
//  MEM_TIMEOUT+1 cycles -> TRAP.
//  TRAP: Halted=1 (registered, set on entry edge), all *_Write=0, all *_Flush=1, inputs ignored,
//  counters frozen.
//  Stall_Count: +1 on each edge with PC_Write=0 in RUN/MEM_WAIT; holds at 2^CNT_W-1.
//  Flush_Count: +1 on each edge where priority 2 or 4 fired (one per cycle); holds at max.
// TESTING
//  1 Reset mid-freeze: Mem_Busy=1 for 3 cycles, then pulse reset -> state RUN, counters 0,
//    Halted=0; outputs forced during reset; all *_Write=1 after release with Mem_Busy=0.
//  2 LW_Stall=1 for 1 cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle;
//    Stall_Count=1.
//  3 LW_Stall=1 and Branch_Taken=1 together -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1;
//    Flush_Count=1, Stall_Count unchanged. LW_Stall=1 and Jump=1 -> stall only.
//  4 MEM_TIMEOUT=4: Mem_Busy=1 for 4 cycles with Jump=1 held -> freeze 4 cycles, Halted=0;
//    cycle 5 IF_ID_Flush=1; Stall_Count=4, Flush_Count=1.
//  5 MEM_TIMEOUT=4: Mem_Busy=1 for 5 cycles -> Halted=1 after 5th edge; then all *_Write=0
//    even with Mem_Busy=0; counters frozen until reset.
//  6 CNT_W=3: hold LW_Stall=1 for 10 cycles -> Stall_Count saturates at 7, no wrap.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard, redirect and memory-busy requests into
// per-stage write-enable/flush controls, traps a stuck memory, and keeps saturating counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LW_Stall,
  input  logic             Jump,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             Halted,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]    WAIT_MAX = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0]    WAIT_ONE = WW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_e;

  state_e             state_q, state_d;
  logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               redirect;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    redirect     = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (reset || state_q == TRAP) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else begin
      // Held requests are ignored while frozen and act in the first non-busy cycle.
      if (Mem_Busy) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Flush = 1'b1;
      end else if (Branch_Taken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        redirect    = 1'b1;
      end else if (LW_Stall) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end else if (Jump) begin
        IF_ID_Flush = 1'b1;
        redirect    = 1'b1;
      end

      case (state_q)
        RUN: begin
          if (Mem_Busy) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_ONE;
          end
        end
        MEM_WAIT: begin
          if (!Mem_Busy) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_MAX) begin
            state_d = TRAP;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end
        default: state_d = state_q;
      endcase

      if (!PC_Write && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (redirect && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    halted_d = (state_d == TRAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Halted      = halted_q;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule
